// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver FSM states, default bit divisor and IO register offsets
// shared by the UART receiver and the system decode.
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_e;
    localparam int DEFAULT_DIVISOR = 868;
    localparam logic [15:0] UART_DATA_ADDR = 16'hfe08;
    localparam logic [15:0] UART_STATUS_ADDR = 16'hfe09;
endpackage

// File: rtl/uart_rx_sync2.sv
// uart_rx_sync2: generic two-flop synchroniser for asynchronous input pins,
// preset to RESET_VAL so an idle-high line stays idle through reset.
module uart_rx_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_b,
    input  logic d,
    output logic q
);
    logic meta_q;
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte holding register and sticky
// framing/overrun status, cleared by a CPU read strobe.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DIVISOR = DEFAULT_DIVISOR,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_err,
    output logic       overrun_err,
    output logic       busy
);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR - 1);

    logic             rxd_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitidx_q, bitidx_d;
    logic [7:0]       shift_q, shift_d;
    logic             load_q, load_d;
    logic             stop_bad_q, stop_bad_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             fe_q, fe_d;
    logic             oe_q, oe_d;

    uart_rx_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_b (reset_b),
        .d       (rxd),
        .q       (rxd_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bitidx_d   = bitidx_q;
        shift_d    = shift_q;
        load_d     = 1'b0;
        stop_bad_d = stop_bad_q;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = rxd_s ? IDLE : START;
            end
            START: if (cnt_q == HALF_LAST) begin
                cnt_d    = '0;
                bitidx_d = 3'd0;
                state_d  = rxd_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == BIT_LAST) begin
                cnt_d            = '0;
                shift_d[bitidx_q] = rxd_s;
                bitidx_d         = bitidx_q + 3'd1;
                state_d          = (bitidx_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt_q == BIT_LAST) begin
                cnt_d      = '0;
                load_d     = 1'b1;
                stop_bad_d = !rxd_s;
                state_d    = rxd_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                cnt_d   = '0;
                state_d = rxd_s ? IDLE : WAIT_HIGH;
            end
            default: state_d = IDLE;
        endcase
    end

    // A load in the same cycle as rd wins: the new byte stays valid and any error it raises survives.
    always_comb begin
        data_d  = load_q ? shift_q : data_q;
        valid_d = load_q | (valid_q & ~rd);
        oe_d    = (load_q & valid_q & ~rd) | (oe_q & ~rd);
        fe_d    = (load_q & stop_bad_q) | (fe_q & ~rd);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitidx_q   <= '0;
            shift_q    <= '0;
            load_q     <= 1'b0;
            stop_bad_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fe_q       <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitidx_q   <= bitidx_d;
            shift_q    <= shift_d;
            load_q     <= load_d;
            stop_bad_q <= stop_bad_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fe_q       <= fe_d;
            oe_q       <= oe_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign framing_err = fe_q;
    assign overrun_err = oe_q;
    assign busy        = (state_q != IDLE);
endmodule
